// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N-channel push-button conditioner.
// Each channel: polarity fix, two-flop synchroniser, stability counter and an
// IDLE/HELD state machine producing a registered level plus one-cycle press,
// release and long-press strobes.
module btn_debounce_multi #(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 24,
  parameter int DEBOUNCE_CYC = 100,
  parameter int LONG_CYC     = 0,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_e;

  // Count value on which a level change is accepted; DEBOUNCE_CYC >= 1.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  // Long-press saturation value; zero disables the long counter entirely.
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYC);
  localparam logic [N_CH-1:0]  POL_MASK = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

  logic [N_CH-1:0] sync0_q;
  logic [N_CH-1:0] sync1_q;

  // Two-flop synchroniser on the polarity-corrected raw inputs (1 = pressed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= {N_CH{1'b0}};
      sync1_q <= {N_CH{1'b0}};
    end else begin
      sync0_q <= btn_raw ^ POL_MASK;
      sync1_q <= sync0_q;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] long_q, long_d;
    logic             level_q;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             lp_q, lp_d;

    // Next-state logic: debounce acceptance in both states, long-press count in HELD.
    always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      long_d  = long_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      lp_d    = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sync1_q[i]) begin
            if (deb_q == DEB_LAST) begin
              state_d = ST_HELD;
              deb_d   = {CNT_W{1'b0}};
              long_d  = {CNT_W{1'b0}};
              press_d = 1'b1;
            end else begin
              deb_d = deb_q + CNT_W'(1);
            end
          end else begin
            deb_d = {CNT_W{1'b0}};
          end
        end
        ST_HELD: begin
          if (!sync1_q[i]) begin
            if (deb_q == DEB_LAST) begin
              state_d = ST_IDLE;
              deb_d   = {CNT_W{1'b0}};
              long_d  = {CNT_W{1'b0}};
              rel_d   = 1'b1;
            end else begin
              deb_d = deb_q + CNT_W'(1);
            end
          end else begin
            deb_d = {CNT_W{1'b0}};
          end
          // Unaccepted bounces leave the long counter running; it saturates so it fires once.
          if ((state_d == ST_HELD) && (long_q < LONG_LIM)) begin
            long_d = long_q + CNT_W'(1);
            lp_d   = ((long_q + CNT_W'(1)) == LONG_LIM);
          end else begin
            lp_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          deb_d   = {CNT_W{1'b0}};
          long_d  = {CNT_W{1'b0}};
        end
      endcase
    end

    // Channel state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        deb_q   <= {CNT_W{1'b0}};
        long_q  <= {CNT_W{1'b0}};
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        lp_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        deb_q   <= deb_d;
        long_q  <= long_d;
        level_q <= (state_d == ST_HELD);
        press_q <= press_d;
        rel_q   <= rel_d;
        lp_q    <= lp_d;
      end
    end

    assign btn_level[i]     = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = rel_q;
    assign long_pulse[i]    = lp_q;
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: two DUTs (active-high and active-low raw
// polarity, fed complementary raw) are checked every cycle against an
// event scoreboard of expected strobes; expected level follows the strobes.
module tb_btn_debounce_multi;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] raw_s = 2'b00;
  logic [1:0] raw_b_s;
  logic [1:0] lvl_a, prs_a, rel_a, lng_a;
  logic [1:0] lvl_b, prs_b, rel_b, lng_b;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [1:0] lvl_exp = 2'b00;

  typedef struct {
    int         edge_n;
    int         kind;   // 0 press, 1 release, 2 long
    logic [1:0] mask;
  } ev_t;
  ev_t sb_q[$];

  typedef struct {
    logic [1:0] raw;
    int         n;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] l;
  } vec_t;
  vec_t tbl[$];

  assign raw_b_s = ~raw_s;

  btn_debounce_multi #(.N_CH(2), .CNT_W(24), .DEBOUNCE_CYC(4), .LONG_CYC(20), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_s), .btn_level(lvl_a),
    .press_pulse(prs_a), .release_pulse(rel_a), .long_pulse(lng_a));

  btn_debounce_multi #(.N_CH(2), .CNT_W(24), .DEBOUNCE_CYC(4), .LONG_CYC(20), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_b_s), .btn_level(lvl_b),
    .press_pulse(prs_b), .release_pulse(rel_b), .long_pulse(lng_b));

  always #5 clk = ~clk;

  // Edge counter: after posedge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  function automatic void push_ev(input int e, input int k, input logic [1:0] m);
    ev_t ev;
    int  i;
    if (m == 2'b00) return;
    ev.edge_n = e;
    ev.kind   = k;
    ev.mask   = m;
    i = 0;
    while (i < sb_q.size() && sb_q[i].edge_n <= e) i++;
    sb_q.insert(i, ev);
  endfunction

  function automatic void add_vec(input logic [1:0] raw, input int n,
                                  input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
    vec_t v;
    v.raw = raw; v.n = n; v.p = p; v.r = r; v.l = l;
    tbl.push_back(v);
  endfunction

  // Drive raw for n cycles; E = next edge samples it. Press/release at E+5, long at E+25.
  task automatic drive(input logic [1:0] raw, input int n,
                       input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
    int e;
    raw_s = raw;
    e = cyc + 1;
    push_ev(e + 5, 0, p);
    push_ev(e + 5, 1, r);
    push_ev(e + 25, 2, l);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Per-cycle monitor: pop events due this edge and compare both DUTs.
  always @(negedge clk) begin
    logic [1:0] ep, er, el;
    if (mon_en) begin
      ep = 2'b00; er = 2'b00; el = 2'b00;
      while (sb_q.size() > 0 && sb_q[0].edge_n <= cyc) begin
        if (sb_q[0].edge_n < cyc) begin
          total++;
          bad++;
          $display("FAIL stale_event edge=%0d actual=none expected_at=%0d", cyc, sb_q[0].edge_n);
        end else begin
          case (sb_q[0].kind)
            0:       ep = ep | sb_q[0].mask;
            1:       er = er | sb_q[0].mask;
            default: el = el | sb_q[0].mask;
          endcase
        end
        void'(sb_q.pop_front());
      end
      if (!rst_n) lvl_exp = 2'b00;
      else        lvl_exp = (lvl_exp | ep) & ~er;
      check("press_a", prs_a, ep);
      check("release_a", rel_a, er);
      check("long_a", lng_a, el);
      check("level_a", lvl_a, lvl_exp);
      check("press_b", prs_b, ep);
      check("release_b", rel_b, er);
      check("long_b", lng_b, el);
      check("level_b", lvl_b, lvl_exp);
    end
  end

  initial begin
    // Scenario 1: reset for 3 cycles, then idle.
    add_vec(2'b00, 50, 2'b00, 2'b00, 2'b00);
    // Scenario 2: clean press (held 40, long fires) and release on ch0.
    add_vec(2'b01, 40, 2'b01, 2'b00, 2'b01);
    add_vec(2'b00, 20, 2'b00, 2'b01, 2'b00);
    // Scenario 3: 5 bounces of 3-high/1-low, then a real short press.
    for (int k = 0; k < 5; k++) begin
      add_vec(2'b01, 3, 2'b00, 2'b00, 2'b00);
      add_vec(2'b00, 1, 2'b00, 2'b00, 2'b00);
    end
    add_vec(2'b01, 10, 2'b01, 2'b00, 2'b00);
    add_vec(2'b00, 20, 2'b00, 2'b01, 2'b00);
    // Scenario 4: ch1 held 60 cycles with a 2-cycle glitch at cycle 15.
    add_vec(2'b10, 15, 2'b10, 2'b00, 2'b10);
    add_vec(2'b00, 2,  2'b00, 2'b00, 2'b00);
    add_vec(2'b10, 43, 2'b00, 2'b00, 2'b00);
    add_vec(2'b00, 20, 2'b00, 2'b10, 2'b00);
    // Scenario 5: both channels on the same edge.
    add_vec(2'b11, 30, 2'b11, 2'b00, 2'b11);
    add_vec(2'b00, 20, 2'b00, 2'b11, 2'b00);

    rst_n  = 1'b0;
    raw_s  = 2'b00;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int t = 0; t < tbl.size(); t++) begin
      drive(tbl[t].raw, tbl[t].n, tbl[t].p, tbl[t].r, tbl[t].l);
    end

    // Scenario 6: reset mid-hold, button held through reset.
    begin
      int e;
      raw_s = 2'b01;
      e = cyc + 1;
      push_ev(e + 5, 0, 2'b01);
      repeat (15) begin
        @(posedge clk);
        #1;
      end
      check("pre_reset_level_a", lvl_a, 2'b01);
      rst_n = 1'b0;
      #1;
      check("async_rst_level_a", lvl_a, 2'b00);
      check("async_rst_level_b", lvl_b, 2'b00);
      check("async_rst_strobes_a", prs_a | rel_a | lng_a, 2'b00);
      check("async_rst_strobes_b", prs_b | rel_b | lng_b, 2'b00);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_ev(cyc + 6, 0, 2'b01);
      push_ev(cyc + 26, 2, 2'b01);
      repeat (40) begin
        @(posedge clk);
        #1;
      end
      drive(2'b00, 20, 2'b00, 2'b01, 2'b00);
    end

    repeat (30) @(posedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised multi-channel push-button conditioner that replaces the single-channel fixed-count debouncer. Each channel has a two-flop synchroniser, a configurable stability counter and a per-channel state machine. Each channel produces a clean registered level plus single-cycle press, release and long-press strobes. It sits between the board push-buttons and the access-control FSM / CNN-inference trigger logic. All channels share one clock and reset.

## Interface
- N_CH, 4: number of independent button channels (>= 1).
- CNT_W, 24: width of each channel's debounce and long-press counters.
- DEBOUNCE_CYC, 100: consecutive stable cycles required to accept a level change (1 .. 2^CNT_W-1).
- LONG_CYC, 0: cycles a press must be held after acceptance to fire long_pulse; 0 disables long-press (long_pulse stays 0).
- ACTIVE_LOW, 0: 1 = raw input reads 0 when pressed; raw is inverted before the synchroniser.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_raw  in  N_CH  raw, asynchronous button inputs.
- btn_level  out  N_CH  debounced level, 1 = pressed.
- press_pulse  out  N_CH  one-cycle strobe when a press is accepted.
- release_pulse  out  N_CH  one-cycle strobe when a release is accepted.
- long_pulse  out  N_CH  one-cycle strobe, at most once per press, when the hold reaches LONG_CYC.

## Operation
- Per channel, p = btn_raw[i] ^ ACTIVE_LOW feeds sync0 -> sync1. Both flops reset to 0 (released).
- State machine per channel:
  - IDLE (level 0): if sync1 = 0, hold the debounce count at 0. If sync1 = 1, increment the count. When the count = DEBOUNCE_CYC-1 and sync1 is still 1, go to HELD on the next edge, set level = 1, pulse press_pulse, clear the count.
  - HELD (level 1): mirror of IDLE on sync1 = 0. On acceptance go to IDLE, set level = 0, pulse release_pulse, clear both counters.
- Any cycle where sync1 equals the current level clears the debounce count (glitch rejection). There is no partial credit.
- Long-press counter: runs only in HELD. It clears on entry to HELD and increments each cycle until it saturates at LONG_CYC. long_pulse fires on the edge where it reaches LONG_CYC.
  - A bounce during HELD that is not accepted does not disturb the long counter.
  - A long-press never fires twice in one press.
- Arithmetic is unsigned CNT_W-bit. Counters never wrap: the debounce count is bounded by DEBOUNCE_CYC-1 and the long count saturates.
- Channels are fully independent. Simultaneous events on several channels assert their strobes in the same cycle.
- press_pulse and long_pulse on the same channel never coincide (LONG_CYC >= 1 edge after entry).

## Timing
- Reset: while rst_n = 0, every state is IDLE, all counters are 0, sync flops are 0, and all outputs are 0, immediately and asynchronously. Deassertion takes effect on the first clk edge with rst_n = 1.
- Latency, measured from edge E, the first edge that samples a new raw value into sync0: sync1 shows it after E+1.
  - With raw held stable, btn_level and press_pulse / release_pulse update at edge E+1+DEBOUNCE_CYC.
  - For DEBOUNCE_CYC = 1, the latency is 2 edges.
- Strobes are exactly one cycle high. They are registered, with no combinational path from btn_raw.
- long_pulse is high for exactly one cycle, LONG_CYC edges after the edge that raised press_pulse.
- Button held through reset: after deassertion it is treated as a new press, with press_pulse at the normal latency.
- Reset mid-debounce or mid-hold: the count is lost and no strobe is issued.

## Test plan
Bench parameters for all scenarios: N_CH = 2, DEBOUNCE_CYC = 4, LONG_CYC = 20, ACTIVE_LOW = 0.
1. Reset / idle: rst_n = 0 for 3 cycles, then 1, with raw = 0 -> all outputs 0 for 50 cycles.
2. Clean press and release: raw[0] 0->1 sampled at edge E, held 40 cycles -> btn_level[0] = 1 and press_pulse[0] one cycle at E+5. Raw back to 0 at edge F -> release_pulse[0] at F+5, level 0. Channel 1 stays quiet.
3. Bounce rejection: raw[0] pulses 1 for 3 cycles, 0 for 1, repeated 5 times -> no strobes, level stays 0. Then hold 1 for 4+ cycles -> exactly one press_pulse.
4. Long press with bounce: hold raw[1] for 60 cycles with a 2-cycle 0-glitch at cycle 15 -> press_pulse[1] once, long_pulse[1] exactly 20 edges later, once, with no release.
5. Simultaneous channels plus ACTIVE_LOW = 1 rerun: both raws asserted on the same edge -> press_pulse = 2'b11 in the same cycle. With inverted polarity, raw = 1 at rest gives level 0.
6. Reset mid-hold: press accepted, rst_n low at hold cycle 10 with raw still 1 -> outputs 0 at once, no long_pulse. After release of reset: press_pulse at deassert edge + 6, long_pulse 20 edges after that.
